// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation search controller.
package sar_pkg;

  localparam int unsigned SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRIAL = 2'd1,
    S_DONE  = 2'd2
  } sar_state_t;

endpackage

// File: rtl/sar_bias_map.sv
// Maps an offset-binary code onto the comparator B encoding; identity when unsigned,
// MSB inverted when signed so offset order matches two's-complement order.
module sar_bias_map
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic [WIDTH-1:0] i_code,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_biased
);

  always_comb begin
    o_biased            = i_code;
    o_biased[WIDTH-1]   = i_code[WIDTH-1] ^ i_sign;
  end

endmodule

// File: rtl/sar_search_4bit.sv
// SAR search controller: recovers the comparator A operand one bit per clock, MSB first.
// Optional build macro SAR_EARLY_EXIT_EN ends the search on the first equality trial.
module sar_search_4bit
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  output logic [WIDTH-1:0] cmp_b,
  output logic             cmp_sign,
  input  logic             a_eq_b,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             flag_err
);

  localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_t       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [KW-1:0]    r_k;
  logic             r_sign;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_trial_b;
  logic [WIDTH-1:0] w_result_b;
  logic             w_ge;
  logic             w_onehot;
  logic             w_last;

  assign w_trial    = r_acc | (WIDTH'(1) << r_k);
  assign w_ge       = a_eq_b | a_gt_b;
  assign w_acc_next = w_ge ? w_trial : r_acc;

  always_comb begin
    case ({a_eq_b, a_gt_b, a_lt_b})
      3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
      default:                w_onehot = 1'b0;
    endcase
  end

`ifdef SAR_EARLY_EXIT_EN
  assign w_last = (r_k == '0) || a_eq_b;
`else
  assign w_last = (r_k == '0);
`endif

  sar_bias_map #(.WIDTH(WIDTH)) u_bias_trial (
    .i_code   (w_trial),
    .i_sign   (r_sign),
    .o_biased (w_trial_b)
  );

  // On an equality exit w_acc_next equals w_trial, so this also yields cmp_b.
  sar_bias_map #(.WIDTH(WIDTH)) u_bias_result (
    .i_code   (w_acc_next),
    .i_sign   (r_sign),
    .o_biased (w_result_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_k      <= KW'(WIDTH - 1);
      r_sign   <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sign  <= sign;
            r_acc   <= '0;
            r_k     <= KW'(WIDTH - 1);
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_TRIAL;
          end
        end
        S_TRIAL: begin
          if (!w_onehot) r_err <= 1'b1;
          r_acc <= w_acc_next;
          r_k   <= r_k - KW'(1);
          if (w_last) begin
            r_result <= w_result_b;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmp_b    = (r_state == S_TRIAL) ? w_trial_b : '0;
  assign cmp_sign = r_sign;
  assign result   = r_result;
  assign busy     = r_busy;
  assign done     = r_done;
  assign flag_err = r_err;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Bench for sar_search_4bit with a behavioural comparator and an integer-range search reference.
module tb_sar_search_4bit;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sign;
  logic [3:0] cmp_b;
  logic       cmp_sign;
  logic       a_eq_b, a_gt_b, a_lt_b;
  logic [3:0] result;
  logic       busy, done, flag_err;

  logic [3:0] a_val;
  logic       force_err;
  logic       exp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sar_search_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .cmp_b    (cmp_b),
    .cmp_sign (cmp_sign),
    .a_eq_b   (a_eq_b),
    .a_gt_b   (a_gt_b),
    .a_lt_b   (a_lt_b),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .flag_err (flag_err)
  );

  // Comparator model; force_err injects an illegal gt+lt combination.
  always_comb begin
    a_eq_b = 1'b0;
    a_gt_b = 1'b0;
    a_lt_b = 1'b0;
    if (force_err) begin
      a_gt_b = 1'b1;
      a_lt_b = 1'b1;
    end else if (cmp_sign) begin
      a_eq_b = $signed(a_val) == $signed(cmp_b);
      a_gt_b = $signed(a_val) >  $signed(cmp_b);
      a_lt_b = $signed(a_val) <  $signed(cmp_b);
    end else begin
      a_eq_b = a_val == cmp_b;
      a_gt_b = a_val >  cmp_b;
      a_lt_b = a_val <  cmp_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Binary search over the integer range: trial = low bound + 2^k, keep it if A >= trial.
  task automatic ref_trials(input logic [3:0] a, input bit sgn, output int t[4], output int n);
    int lo, va, tv;
    va = sgn ? int'($signed(a)) : int'(a);
    lo = sgn ? -8 : 0;
    n  = 4;
    for (int i = 0; i < 4; i++) t[i] = 0;
    for (int i = 0; i < 4; i++) begin
      tv   = lo + (1 << (3 - i));
      t[i] = tv & 15;
      if (EARLY && tv == va) begin
        n = i + 1;
        break;
      end
      if (va >= tv) lo = tv;
    end
  endtask

  task automatic run_search(input logic [3:0] a, input bit sgn, input int err_trial,
                            input bit poke_busy, input bit poke_done);
    int t[4];
    int n;
    ref_trials(a, sgn, t, n);
    a_val   = a;
    exp_err = 1'b0;
    @(negedge clk);
    start = 1'b1;
    sign  = sgn;
    @(negedge clk);
    start = 1'b0;
    sign  = ~sgn;
    for (int i = 0; i < n; i++) begin
      chk("busy_trial", 32'(busy), 32'd1);
      chk("done_trial", 32'(done), 32'd0);
      chk("cmp_b", 32'(cmp_b), 32'(t[i]));
      chk("cmp_sign", 32'(cmp_sign), 32'(sgn));
      chk("flag_err_trial", 32'(flag_err), 32'(exp_err));
      if (i == err_trial) force_err = 1'b1;
      if (poke_busy && i == 1) start = 1'b1;
      @(negedge clk);
      if (i == err_trial) exp_err = 1'b1;
      force_err = 1'b0;
      start     = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("result", 32'(result), 32'(a));
    chk("cmp_b_done", 32'(cmp_b), 32'd0);
    chk("flag_err_done", 32'(flag_err), 32'(exp_err));
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_after", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("result_hold", 32'(result), 32'(a));
    chk("flag_err_hold", 32'(flag_err), 32'(exp_err));
    chk("cmp_b_idle", 32'(cmp_b), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    sign      = 1'b0;
    a_val     = 4'd0;
    force_err = 1'b0;
    exp_err   = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cmp_b", 32'(cmp_b), 32'd0);
    chk("rst_cmp_sign", 32'(cmp_sign), 32'd0);
    chk("rst_flag_err", 32'(flag_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_search(4'b1011, 1'b0, -1, 1'b0, 1'b0);
    run_search(4'b1100, 1'b1, -1, 1'b0, 1'b0);
    run_search(4'b1000, 1'b1, -1, 1'b0, 1'b0);
    run_search(4'b0111, 1'b1, -1, 1'b0, 1'b0);
    run_search(4'b0000, 1'b0, -1, 1'b0, 1'b0);
    run_search(4'b1111, 1'b0, -1, 1'b0, 1'b0);
    run_search(4'b1011, 1'b0, 3, 1'b0, 1'b0);
    run_search(4'b0101, 1'b0, -1, 1'b1, 1'b1);
    run_search(4'b1101, 1'b1, -1, 1'b1, 1'b0);

    a_val = 4'b1011;
    @(negedge clk);
    start = 1'b1;
    sign  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_result", 32'(result), 32'd0);
    chk("mid_cmp_b", 32'(cmp_b), 32'd0);
    chk("mid_cmp_sign", 32'(cmp_sign), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_search(4'b0110, 1'b0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      run_search(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
